issue_align: RTL and testbench

Dual-slot issue aligner between the fetch FIFO and the ID stage. Each cycle it pops at most one two-instruction fetch packet from the FIFO and registers it. It then presents the valid instructions to ID as an in-order pair, oldest always in slot 0. When ID accepts only part of a pair, it holds the remainder and shifts it into slot 0. It also suppresses instructions that must not issue: anything after a predicted-taken branch, after a fetch exception, or after a privileged instruction.

---
 rtl/issue_align_pkg.sv | 36 +++
 rtl/issue_slot_reg.sv | 26 ++
 rtl/issue_align.sv | 136 +++++++++++++
 tb/tb_issue_align.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/issue_align_pkg.sv
// Shared definitions for the dual-slot issue aligner: invalid-slot defaults,
// state encoding, ID accept encodings and the per-slot payload record.
package issue_align_pkg;

  localparam logic [31:0] INST_NOP_DEF = 32'h0340_0000;
  localparam logic [31:0] PC_RESET_DEF = 32'h1c00_0000;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'b00,
    ST_PAIR   = 2'b01,
    ST_SINGLE = 2'b10
  } state_e;

  localparam logic [1:0] ACC_NONE = 2'b00;
  localparam logic [1:0] ACC_S0   = 2'b01;
  localparam logic [1:0] ACC_BOTH = 2'b11;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        taken;
    logic        branch;
    logic        priv;
  } slot_t;

  function automatic slot_t empty_slot(input logic [31:0] nop, input logic [31:0] pc_rst);
    slot_t s;
    s.inst   = nop;
    s.pc     = pc_rst;
    s.taken  = 1'b0;
    s.branch = 1'b0;
    s.priv   = 1'b0;
    return s;
  endfunction

endpackage

// File: rtl/issue_slot_reg.sv
// One issue slot: holds inst/pc/predecode bits. Clear wins over load, load over shift;
// a cleared slot holds the invalid-slot values so outputs need no muxing.
module issue_slot_reg
  import issue_align_pkg::*;
#(
  parameter logic [31:0] INST_NOP = INST_NOP_DEF,
  parameter logic [31:0] PC_RESET = PC_RESET_DEF
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  clear,
  input  logic  load,
  input  logic  shift,
  input  slot_t load_data,
  input  slot_t shift_data,
  output slot_t q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        q <= empty_slot(INST_NOP, PC_RESET);
    else if (clear) q <= empty_slot(INST_NOP, PC_RESET);
    else if (load)  q <= load_data;
    else if (shift) q <= shift_data;
  end

endmodule

// File: rtl/issue_align.sv
// Dual-slot issue aligner: pops fetch packets, issues them oldest-first in slot 0,
// holds/shifts partially accepted pairs, and suppresses slots after taken/fault/priv.
module issue_align
  import issue_align_pkg::*;
#(
  parameter logic [31:0] INST_NOP = INST_NOP_DEF,
  parameter logic [31:0] PC_RESET = PC_RESET_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        fifo_valid,
  output logic        fifo_ready,
  input  logic [31:0] fifo_inst0,
  input  logic [31:0] fifo_inst1,
  input  logic [31:0] fifo_pc,
  input  logic [31:0] fifo_pc_next,
  input  logic [1:0]  fifo_pc_taken,
  input  logic [31:0] fifo_badv,
  input  logic [6:0]  fifo_exception,
  input  logic [1:0]  fifo_excp_flag,
  input  logic [1:0]  fifo_priv_flag,
  input  logic [1:0]  fifo_branch_flag,
  input  logic [1:0]  id_accept,
  output logic [1:0]  id_valid,
  output logic [31:0] id_inst0,
  output logic [31:0] id_inst1,
  output logic [31:0] id_pc0,
  output logic [31:0] id_pc1,
  output logic [1:0]  id_taken,
  output logic [1:0]  id_branch,
  output logic [1:0]  id_priv,
  output logic [31:0] id_target,
  output logic [6:0]  id_excp,
  output logic [1:0]  id_excp_flag,
  output logic [31:0] id_badv
);

  state_e      state;
  logic [31:0] target;
  logic [6:0]  excp;
  logic [1:0]  excp_flag;
  logic [31:0] badv;

  slot_t       s0, s1;
  slot_t       ld0, ld1;
  logic [1:0]  acc_eff;
  logic        consume_all, pop, shift_one, slot1_ok;
  logic        clear0, clear1;

  always_comb begin
    acc_eff = (id_accept == 2'b10) ? ACC_NONE : id_accept;
    if (state == ST_SINGLE && acc_eff == ACC_BOTH) acc_eff = ACC_S0;
    consume_all = (state == ST_PAIR   && acc_eff == ACC_BOTH) ||
                  (state == ST_SINGLE && acc_eff == ACC_S0);
    fifo_ready  = !flush && !rst && (state == ST_EMPTY || consume_all);
    pop         = fifo_ready && fifo_valid;
    shift_one   = !flush && !pop && state == ST_PAIR && acc_eff == ACC_S0;
    // Slot 1 is younger than any taken branch, fault or privileged op in slot 0.
    slot1_ok    = !fifo_pc_taken[0] && (fifo_excp_flag == 2'b00) && !fifo_priv_flag[0];
    clear0      = flush || (consume_all && !pop);
    clear1      = clear0 || shift_one;

    ld0.inst    = fifo_inst0;
    ld0.pc      = fifo_pc;
    ld0.taken   = fifo_pc_taken[0];
    ld0.branch  = fifo_branch_flag[0];
    ld0.priv    = fifo_priv_flag[0];
    ld1         = empty_slot(INST_NOP, PC_RESET);
    if (slot1_ok) begin
      ld1.inst   = fifo_inst1;
      ld1.pc     = fifo_pc + 32'd4;
      ld1.taken  = fifo_pc_taken[1];
      ld1.branch = fifo_branch_flag[1];
      ld1.priv   = fifo_priv_flag[1];
    end
  end

  issue_slot_reg #(.INST_NOP(INST_NOP), .PC_RESET(PC_RESET)) u_slot0 (
    .clk(clk), .rst(rst), .clear(clear0), .load(pop), .shift(shift_one),
    .load_data(ld0), .shift_data(s1), .q(s0)
  );

  issue_slot_reg #(.INST_NOP(INST_NOP), .PC_RESET(PC_RESET)) u_slot1 (
    .clk(clk), .rst(rst), .clear(clear1), .load(pop), .shift(1'b0),
    .load_data(ld1), .shift_data(ld1), .q(s1)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_EMPTY;
      target    <= PC_RESET + 32'd8;
      excp      <= '0;
      excp_flag <= '0;
      badv      <= '0;
    end else if (flush) begin
      state     <= ST_EMPTY;
      excp      <= '0;
      excp_flag <= '0;
      badv      <= '0;
    end else if (pop) begin
      state     <= slot1_ok ? ST_PAIR : ST_SINGLE;
      target    <= fifo_pc_next;
      excp      <= fifo_exception;
      excp_flag <= fifo_excp_flag;
      badv      <= fifo_badv;
    end else if (consume_all || shift_one) begin
      // Fault fields belong to the packet's inst0 only; drop them once it leaves.
      state     <= consume_all ? ST_EMPTY : ST_SINGLE;
      excp      <= '0;
      excp_flag <= '0;
      badv      <= '0;
    end
  end

  always_comb begin
    case (state)
      ST_PAIR:   id_valid = 2'b11;
      ST_SINGLE: id_valid = 2'b01;
      default:   id_valid = 2'b00;
    endcase
  end

  assign id_inst0     = s0.inst;
  assign id_inst1     = s1.inst;
  assign id_pc0       = s0.pc;
  assign id_pc1       = s1.pc;
  assign id_taken     = {s1.taken,  s0.taken};
  assign id_branch    = {s1.branch, s0.branch};
  assign id_priv      = {s1.priv,   s0.priv};
  assign id_target    = target;
  assign id_excp      = excp;
  assign id_excp_flag = excp_flag;
  assign id_badv      = badv;

endmodule

// File: tb/tb_issue_align.sv
// Directed table-driven bench for issue_align plus hand sequences for stall and async reset.
module tb_issue_align;

  localparam logic [31:0] NOP = 32'h0340_0000;
  localparam logic [31:0] PR  = 32'h1c00_0000;
  localparam logic [31:0] BAD = 32'hBAD0_0000;

  logic        clk = 1'b0;
  logic        rst, flush, fifo_valid, fifo_ready;
  logic [31:0] fifo_inst0, fifo_inst1, fifo_pc, fifo_pc_next, fifo_badv;
  logic [1:0]  fifo_pc_taken, fifo_excp_flag, fifo_priv_flag, fifo_branch_flag, id_accept;
  logic [6:0]  fifo_exception;
  logic [1:0]  id_valid, id_taken, id_branch, id_priv, id_excp_flag;
  logic [31:0] id_inst0, id_inst1, id_pc0, id_pc1, id_target, id_badv;
  logic [6:0]  id_excp;

  int errs = 0;
  int nchk = 0;

  issue_align dut (
    .clk(clk), .rst(rst), .flush(flush), .fifo_valid(fifo_valid), .fifo_ready(fifo_ready),
    .fifo_inst0(fifo_inst0), .fifo_inst1(fifo_inst1), .fifo_pc(fifo_pc),
    .fifo_pc_next(fifo_pc_next), .fifo_pc_taken(fifo_pc_taken), .fifo_badv(fifo_badv),
    .fifo_exception(fifo_exception), .fifo_excp_flag(fifo_excp_flag),
    .fifo_priv_flag(fifo_priv_flag), .fifo_branch_flag(fifo_branch_flag),
    .id_accept(id_accept), .id_valid(id_valid), .id_inst0(id_inst0), .id_inst1(id_inst1),
    .id_pc0(id_pc0), .id_pc1(id_pc1), .id_taken(id_taken), .id_branch(id_branch),
    .id_priv(id_priv), .id_target(id_target), .id_excp(id_excp),
    .id_excp_flag(id_excp_flag), .id_badv(id_badv)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!rst) assert (id_accept != 2'b10) else $error("illegal id_accept 10");

  typedef struct {
    logic        fl, fv;
    logic [31:0] pc, pcn;
    logic [1:0]  tk, ef, pf, acc;
    logic        rdy;
    logic [1:0]  vld;
    logic [31:0] pc0, pc1, tgt;
    logic        ct;
    logic [1:0]  etk, epv, eef;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [31:0] ifn(input logic [31:0] pc);
    return {8'hA0, pc[23:0]};
  endfunction

  function automatic vec_t mk(input logic fl, fv, input logic [31:0] pc, pcn,
                              input logic [1:0] tk, ef, pf, acc, input logic rdy,
                              input logic [1:0] vld, input logic [31:0] pc0, pc1, tgt,
                              input logic ct, input logic [1:0] etk, epv, eef);
    vec_t v;
    v.fl = fl; v.fv = fv; v.pc = pc; v.pcn = pcn; v.tk = tk; v.ef = ef; v.pf = pf;
    v.acc = acc; v.rdy = rdy; v.vld = vld; v.pc0 = pc0; v.pc1 = pc1; v.tgt = tgt;
    v.ct = ct; v.etk = etk; v.epv = epv; v.eef = eef;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s [%0d]: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic fl, fv, input logic [31:0] pc, pcn,
                       input logic [1:0] tk, ef, pf, acc);
    flush = fl; fifo_valid = fv; fifo_pc = pc; fifo_pc_next = pcn;
    fifo_inst0 = ifn(pc); fifo_inst1 = ifn(pc + 32'd4);
    fifo_pc_taken = tk; fifo_branch_flag = tk; fifo_excp_flag = ef; fifo_priv_flag = pf;
    fifo_exception = (ef != 2'b00) ? 7'h08 : 7'h00;
    fifo_badv = (ef != 2'b00) ? BAD : 32'h0;
    id_accept = acc;
  endtask

  task automatic chk_slots(input int idx, input logic [1:0] vld, input logic [31:0] pc0, pc1);
    chk("id_valid", idx, {30'd0, id_valid}, {30'd0, vld});
    chk("id_pc0",   idx, id_pc0, pc0);
    chk("id_pc1",   idx, id_pc1, pc1);
    chk("id_inst0", idx, id_inst0, vld[0] ? ifn(pc0) : NOP);
    chk("id_inst1", idx, id_inst1, vld[1] ? ifn(pc1) : NOP);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 2'b00, 2'b00, 2'b00);
    tbl.push_back(mk(0,1,32'h1c000000,32'h1c000008,2'b00,2'b00,2'b00,2'b00, 1,2'b11,32'h1c000000,32'h1c000004,32'h1c000008,1,2'b00,2'b00,2'b00));
    tbl.push_back(mk(0,1,32'h1c000008,32'h1c000010,2'b00,2'b00,2'b00,2'b11, 1,2'b11,32'h1c000008,32'h1c00000c,32'h1c000010,1,2'b00,2'b00,2'b00));
    tbl.push_back(mk(0,1,32'h1c000010,32'h1c000018,2'b00,2'b00,2'b00,2'b11, 1,2'b11,32'h1c000010,32'h1c000014,32'h1c000018,1,2'b00,2'b00,2'b00));
    tbl.push_back(mk(0,1,32'h1c000018,32'h1c000020,2'b00,2'b00,2'b00,2'b01, 0,2'b01,32'h1c000014,PR,32'h1c000018,1,2'b00,2'b00,2'b00));
    tbl.push_back(mk(0,1,32'h1c000018,32'h1c000020,2'b00,2'b00,2'b00,2'b01, 1,2'b11,32'h1c000018,32'h1c00001c,32'h1c000020,1,2'b00,2'b00,2'b00));
    tbl.push_back(mk(0,1,32'h1c000020,32'h1c000100,2'b01,2'b00,2'b00,2'b11, 1,2'b01,32'h1c000020,PR,32'h1c000100,1,2'b01,2'b00,2'b00));
    tbl.push_back(mk(0,1,32'h1c000100,32'h1c000108,2'b00,2'b01,2'b00,2'b11, 1,2'b01,32'h1c000100,PR,32'h1c000108,1,2'b00,2'b00,2'b01));
    tbl.push_back(mk(0,1,32'h1c000200,32'h1c000208,2'b00,2'b00,2'b01,2'b01, 1,2'b01,32'h1c000200,PR,32'h1c000208,1,2'b00,2'b01,2'b00));
    tbl.push_back(mk(0,1,32'h1c000300,32'h1c000308,2'b00,2'b00,2'b00,2'b01, 1,2'b11,32'h1c000300,32'h1c000304,32'h1c000308,1,2'b00,2'b00,2'b00));
    tbl.push_back(mk(1,1,32'h1c000400,32'h1c000408,2'b00,2'b00,2'b00,2'b11, 0,2'b00,PR,PR,32'h0,0,2'b00,2'b00,2'b00));
    tbl.push_back(mk(0,0,32'h1c000400,32'h1c000408,2'b00,2'b00,2'b00,2'b00, 1,2'b00,PR,PR,32'h0,0,2'b00,2'b00,2'b00));
    tbl.push_back(mk(0,1,32'h1c000400,32'h1c000408,2'b00,2'b00,2'b00,2'b00, 1,2'b11,32'h1c000400,32'h1c000404,32'h1c000408,1,2'b00,2'b00,2'b00));

    repeat (3) @(posedge clk);
    #1 chk("rst_ready_low", 0, {31'd0, fifo_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk_slots(0, 2'b00, PR, PR);
    chk("rst_ready",  0, {31'd0, fifo_ready}, 32'd1);
    chk("rst_target", 0, id_target, PR + 32'd8);
    chk("rst_excp",   0, {25'd0, id_excp}, 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].fl, tbl[i].fv, tbl[i].pc, tbl[i].pcn, tbl[i].tk, tbl[i].ef, tbl[i].pf, tbl[i].acc);
      #1 chk("fifo_ready", i + 1, {31'd0, fifo_ready}, {31'd0, tbl[i].rdy});
      @(posedge clk); #1;
      chk_slots(i + 1, tbl[i].vld, tbl[i].pc0, tbl[i].pc1);
      if (tbl[i].ct) chk("id_target", i + 1, id_target, tbl[i].tgt);
      chk("id_taken",     i + 1, {30'd0, id_taken},  {30'd0, tbl[i].etk});
      chk("id_branch",    i + 1, {30'd0, id_branch}, {30'd0, tbl[i].etk});
      chk("id_priv",      i + 1, {30'd0, id_priv},   {30'd0, tbl[i].epv});
      chk("id_excp_flag", i + 1, {30'd0, id_excp_flag}, {30'd0, tbl[i].eef});
      chk("id_excp",      i + 1, {25'd0, id_excp}, (tbl[i].eef != 2'b00) ? 32'h8 : 32'h0);
      chk("id_badv",      i + 1, id_badv, (tbl[i].eef != 2'b00) ? BAD : 32'h0);
    end

    // Stall: held pair stays put and nothing is popped.
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, 1'b1, 32'h1c000500, 32'h1c000508, 2'b00, 2'b00, 2'b00, 2'b00);
      #1 chk("stall_ready", 100 + c, {31'd0, fifo_ready}, 32'd0);
      @(posedge clk); #1;
      chk_slots(100 + c, 2'b11, 32'h1c000400, 32'h1c000404);
      chk("stall_target", 100 + c, id_target, 32'h1c000408);
    end

    // Full accept with nothing in the FIFO drains to empty.
    drive(1'b0, 1'b0, 32'h1c000500, 32'h1c000508, 2'b00, 2'b00, 2'b00, 2'b11);
    #1 chk("drain_ready", 200, {31'd0, fifo_ready}, 32'd1);
    @(posedge clk); #1;
    chk_slots(200, 2'b00, PR, PR);

    // Async reset in the middle of a held pair.
    drive(1'b0, 1'b1, 32'h1c000600, 32'h1c000608, 2'b00, 2'b00, 2'b00, 2'b00);
    @(posedge clk); #1;
    chk_slots(300, 2'b11, 32'h1c000600, 32'h1c000604);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 2'b00, 2'b00, 2'b00);
    #2 rst = 1'b1;
    #1;
    chk_slots(301, 2'b00, PR, PR);
    chk("arst_target", 301, id_target, PR + 32'd8);
    chk("arst_ready",  301, {31'd0, fifo_ready}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    #1 chk("arst_ready_rel", 302, {31'd0, fifo_ready}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
